// File: rtl/hazard_stall_ctrl.sv
// Pipeline hazard/stall controller: RAW bubble insertion, branch flush, multi-cycle
// memory stall sequencing, and saturating stall/flush statistics.
module hazard_stall_ctrl #(
  parameter int unsigned MEM_WAIT_CYCLES = 4,
  parameter int unsigned CNT_W           = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [3:0]       id_src1,
  input  logic [3:0]       id_src2,
  input  logic             id_use_src1,
  input  logic             id_two_src,
  input  logic [3:0]       exe_dest,
  input  logic             exe_wb_en,
  input  logic             exe_mem_r_en,
  input  logic [3:0]       mem_dest,
  input  logic             mem_wb_en,
  input  logic             fwd_en,
  input  logic             mem_acc,
  input  logic             branch_taken,
  output logic             freeze_pc,
  output logic             freeze_if_id,
  output logic             freeze_id_ex,
  output logic             freeze_exe_mem,
  output logic             clr_if_id,
  output logic             clr_id_ex,
  output logic             mem_ready,
  output logic [CNT_W-1:0] stall_cnt,
  output logic [CNT_W-1:0] flush_cnt
);

  localparam int unsigned WCNT_W    = $clog2(MEM_WAIT_CYCLES) + 1;
  localparam int unsigned WAIT_LAST = (MEM_WAIT_CYCLES >= 2) ? (MEM_WAIT_CYCLES - 2) : 0;
  localparam bit          MULTI     = (MEM_WAIT_CYCLES >= 2);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_WAIT = 2'd1,
    S_DONE = 2'd2
  } state_t;

  state_t            state;
  state_t            state_nxt;
  logic [WCNT_W-1:0] wcnt;
  logic [WCNT_W-1:0] wcnt_nxt;
  logic              raw_exe;
  logic              raw_mem;
  logic              hazard;
  logic              mem_stall;
  logic              stall_inc;
  logic              flush_inc;

  // RAW detection against the EXE and MEM destinations
  always_comb begin
    raw_exe = exe_wb_en & ((id_use_src1 & (exe_dest == id_src1)) |
                           (id_two_src  & (exe_dest == id_src2)));
    raw_mem = mem_wb_en & ((id_use_src1 & (mem_dest == id_src1)) |
                           (id_two_src  & (mem_dest == id_src2)));
    hazard  = fwd_en ? (raw_exe & exe_mem_r_en) : (raw_exe | raw_mem);
  end

  // Memory FSM state register
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state <= S_IDLE;
      wcnt  <= '0;
    end else begin
      state <= state_nxt;
      wcnt  <= wcnt_nxt;
    end
  end

  // Memory FSM next state
  always_comb begin
    state_nxt = state;
    wcnt_nxt  = wcnt;
    case (state)
      S_IDLE: begin
        if (MULTI && mem_acc) begin
          if (MEM_WAIT_CYCLES == 2) begin
            state_nxt = S_DONE;
          end else begin
            state_nxt = S_WAIT;
            wcnt_nxt  = WCNT_W'(1);
          end
        end
      end
      S_WAIT: begin
        if (wcnt == WCNT_W'(WAIT_LAST)) state_nxt = S_DONE;
        else                            wcnt_nxt  = wcnt + WCNT_W'(1);
      end
      S_DONE:  state_nxt = S_IDLE;
      default: state_nxt = S_IDLE;
    endcase
  end

  // Control outputs: memory stall > branch flush > RAW bubble; all held low in reset
  always_comb begin
    mem_stall      = 1'b0;
    mem_ready      = 1'b0;
    freeze_pc      = 1'b0;
    freeze_if_id   = 1'b0;
    freeze_id_ex   = 1'b0;
    freeze_exe_mem = 1'b0;
    clr_if_id      = 1'b0;
    clr_id_ex      = 1'b0;
    stall_inc      = 1'b0;
    flush_inc      = 1'b0;
    if (rst) begin
      case (state)
        S_IDLE: begin
          mem_stall = MULTI & mem_acc;
          mem_ready = ~MULTI & mem_acc;
        end
        S_WAIT:  mem_stall = 1'b1;
        S_DONE:  mem_ready = 1'b1;
        default: mem_stall = 1'b0;
      endcase
      if (mem_stall) begin
        freeze_pc      = 1'b1;
        freeze_if_id   = 1'b1;
        freeze_id_ex   = 1'b1;
        freeze_exe_mem = 1'b1;
      end else if (branch_taken) begin
        clr_if_id = 1'b1;
        clr_id_ex = 1'b1;
        flush_inc = 1'b1;
      end else if (hazard) begin
        freeze_pc    = 1'b1;
        freeze_if_id = 1'b1;
        clr_id_ex    = 1'b1;
        stall_inc    = 1'b1;
      end
    end
  end

  // Saturating statistics counters
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      stall_cnt <= '0;
      flush_cnt <= '0;
    end else begin
      if (stall_inc && (stall_cnt != '1)) stall_cnt <= stall_cnt + CNT_W'(1);
      if (flush_inc && (flush_cnt != '1)) flush_cnt <= flush_cnt + CNT_W'(1);
    end
  end

endmodule
